id_stage_ctrl: RTL and testbench

Registered instruction-decode stage for the RV32I core. It sits between fetch and execute and turns each fetched instruction into the registered control bundle (memory, writeback, ALU-source, ALU-op, branch/jump flags), plus register indices and the immediate. Generalised over the single-cycle decoder: optional M-extension decode, valid/ready handshakes, load-use interlock, ECALL serialisation, flush, and illegal-opcode flagging.

---
 rtl/id_stage_ctrl_pkg.sv | 76 +++++++
 rtl/id_stage_ctrl_decode.sv | 109 ++++++++++
 rtl/id_stage_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_id_stage_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_ctrl_pkg.sv
// Shared decode constants for the RV32I decode stage: opcodes, ALU codes and the control bundle.
package id_stage_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INSTR_ECALL   = 32'h0000_0073;
    localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_CMP   = 5'b00011;
    localparam logic [4:0] ALU_AND   = 5'b00100;
    localparam logic [4:0] ALU_OR    = 5'b00101;
    localparam logic [4:0] ALU_XOR   = 5'b00110;
    localparam logic [4:0] ALU_LUI   = 5'b00111;
    localparam logic [4:0] ALU_SLT   = 5'b01000;
    localparam logic [4:0] ALU_SLTU  = 5'b01001;
    localparam logic [4:0] ALU_AUIPC = 5'b01010;
    localparam logic [4:0] ALU_SLL   = 5'b01100;
    localparam logic [4:0] ALU_SRL   = 5'b01101;
    localparam logic [4:0] ALU_SRA   = 5'b01110;
    // mul/div family is {1'b1, 1'b0, funct3}
    localparam logic [1:0] ALU_MULDIV_PFX = 2'b10;

    typedef enum logic {
        ST_RUN        = 1'b0,
        ST_ECALL_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic       mem_read;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       beq;
        logic       bne;
        logic       blt;
        logic       bge;
        logic       bltu;
        logic       bgeu;
        logic       lui;
        logic       auipc;
        logic       u_type;
        logic       jal;
        logic       jalr;
        logic       ecall;
        logic       illegal;
        logic [4:0] alu_ctrl;
    } ctrl_t;

    function automatic logic [4:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        logic [4:0] code;
        case (f3)
            3'b000:  code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/id_stage_ctrl_decode.sv
// Pure combinational RV32I(+M) decoder: instruction word to control bundle, immediate and operand usage.
module id_stage_ctrl_decode
    import id_stage_ctrl_pkg::*;
#(
    parameter int RV_M = 0
) (
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic [31:0] imm_o,
    output logic        uses_rs1_o,
    output logic        uses_rs2_o
);

    logic [6:0] opc;
    logic [2:0] f3;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];

    assign uses_rs1_o = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    assign uses_rs2_o = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);

    always_comb begin
        ctrl_o = '0;
        imm_o  = '0;
        case (opc)
            OPC_LOAD: begin
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_STORE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OPC_BRANCH: begin
                ctrl_o.alu_ctrl = ALU_CMP;
                ctrl_o.beq  = (f3 == 3'b000);
                ctrl_o.bne  = (f3 == 3'b001);
                ctrl_o.blt  = (f3 == 3'b100);
                ctrl_o.bge  = (f3 == 3'b101);
                ctrl_o.bltu = (f3 == 3'b110);
                ctrl_o.bgeu = (f3 == 3'b111);
                imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
            end
            OPC_JAL: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.jal       = 1'b1;
                ctrl_o.alu_ctrl  = ALU_CMP;
                imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
            end
            OPC_JALR: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.jalr      = 1'b1;
                imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_OP_IMM: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                // instr[30] is immediate data except on the shift-right form
                ctrl_o.alu_ctrl  = alu_from_funct3(f3, instr_i[30] && (f3 == 3'b101));
                imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_OP: begin
                if (instr_i[31:25] == FUNCT7_MULDIV) begin
                    if (RV_M != 0) begin
                        ctrl_o.reg_write = 1'b1;
                        ctrl_o.alu_ctrl  = {ALU_MULDIV_PFX, f3};
                    end else begin
                        ctrl_o.illegal = 1'b1;
                    end
                end else begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.alu_ctrl  = alu_from_funct3(f3, instr_i[30]);
                end
            end
            OPC_LUI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.lui       = 1'b1;
                ctrl_o.u_type    = 1'b1;
                ctrl_o.alu_ctrl  = ALU_LUI;
                imm_o = {instr_i[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.auipc     = 1'b1;
                ctrl_o.u_type    = 1'b1;
                ctrl_o.alu_ctrl  = ALU_AUIPC;
                imm_o = {instr_i[31:12], 12'b0};
            end
            OPC_SYSTEM: begin
                if (instr_i == INSTR_ECALL) begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.ecall     = 1'b1;
                end else begin
                    ctrl_o.illegal = 1'b1;
                end
            end
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_stage_ctrl.sv
// Registered decode stage: output register, valid/ready handshake, load-use interlock, ECALL serialisation.
//   state          | meaning
//   ST_RUN         | normal decode, accepts when output register is free and no hazard
//   ST_ECALL_WAIT  | ECALL issued, intake blocked until ecall_done_i
module id_stage_ctrl
    import id_stage_ctrl_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int RV_M           = 0,
    parameter int ALU_W          = 4,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_instr_i,
    input  logic [XLEN-1:0]  in_pc_i,
    input  logic             flush_i,
    input  logic             ecall_done_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_pc_o,
    output logic [XLEN-1:0]  out_imm_o,
    output logic [4:0]       out_rs1_o,
    output logic [4:0]       out_rs2_o,
    output logic [4:0]       out_rd_o,
    output logic             mem_read_o,
    output logic             mem_to_reg_o,
    output logic             reg_write_o,
    output logic             alu_src_o,
    output logic             mem_write_o,
    output logic [ALU_W-1:0] alu_control_o,
    output logic             beq_o,
    output logic             bne_o,
    output logic             blt_o,
    output logic             bge_o,
    output logic             bltu_o,
    output logic             bgeu_o,
    output logic             lui_o,
    output logic             auipc_o,
    output logic             u_type_o,
    output logic             jal_o,
    output logic             jalr_o,
    output logic             ecall_o,
    output logic             illegal_o
);

    localparam int LU_W = (LOAD_USE_STALL < 1) ? 1 : $clog2(LOAD_USE_STALL + 1);

    ctrl_t            dec_ctrl;
    logic [31:0]      dec_imm;
    logic             dec_uses_rs1, dec_uses_rs2;
    logic [XLEN-1:0]  imm_ext;
    logic [4:0]       in_rs1, in_rs2, in_rd;
    logic             hazard, out_free, accept;

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [XLEN-1:0]  pc_q, pc_d, imm_q, imm_d;
    logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [LU_W-1:0]  lu_cnt_q, lu_cnt_d;
    logic [4:0]       lu_rd_q, lu_rd_d;

    id_stage_ctrl_decode #(.RV_M(RV_M)) u_decode (
        .instr_i    (in_instr_i),
        .ctrl_o     (dec_ctrl),
        .imm_o      (dec_imm),
        .uses_rs1_o (dec_uses_rs1),
        .uses_rs2_o (dec_uses_rs2)
    );

    assign imm_ext = XLEN'($signed(dec_imm));
    assign in_rs1  = in_instr_i[19:15];
    assign in_rs2  = in_instr_i[24:20];
    assign in_rd   = in_instr_i[11:7];

    assign hazard = (lu_cnt_q != '0) && in_valid_i &&
                    ((dec_uses_rs1 && (in_rs1 == lu_rd_q)) ||
                     (dec_uses_rs2 && (in_rs2 == lu_rd_q)));
    assign out_free   = !out_valid_q || out_ready_i;
    assign in_ready_o = out_free && (state_q == ST_RUN) && !hazard && !flush_i;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        pc_d        = pc_q;
        imm_d       = imm_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        lu_cnt_d    = lu_cnt_q;
        lu_rd_d     = lu_rd_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
            lu_cnt_d    = '0;
            state_d     = ST_RUN;
        end else begin
            if (accept) begin
                out_valid_d = 1'b1;
                ctrl_d      = dec_ctrl;
                pc_d        = in_pc_i;
                imm_d       = imm_ext;
                rs1_d       = in_rs1;
                rs2_d       = in_rs2;
                rd_d        = in_rd;
            end else if (out_free) begin
                out_valid_d = 1'b0;
            end
            // any emitted load freezes the countdown; only rd!=0 rearms it
            if (accept && dec_ctrl.mem_read) begin
                if (in_rd != 5'd0) begin
                    lu_rd_d  = in_rd;
                    lu_cnt_d = LU_W'(LOAD_USE_STALL);
                end
            end else if (out_ready_i && (lu_cnt_q != '0)) begin
                lu_cnt_d = lu_cnt_q - LU_W'(1);
            end
            case (state_q)
                ST_RUN:        if (accept && dec_ctrl.ecall) state_d = ST_ECALL_WAIT;
                ST_ECALL_WAIT: if (ecall_done_i) state_d = ST_RUN;
                default:       state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            lu_cnt_q    <= '0;
            lu_rd_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            lu_cnt_q    <= lu_cnt_d;
            lu_rd_q     <= lu_rd_d;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_pc_o      = pc_q;
    assign out_imm_o     = imm_q;
    assign out_rs1_o     = rs1_q;
    assign out_rs2_o     = rs2_q;
    assign out_rd_o      = rd_q;
    assign mem_read_o    = ctrl_q.mem_read;
    assign mem_to_reg_o  = ctrl_q.mem_to_reg;
    assign reg_write_o   = ctrl_q.reg_write;
    assign alu_src_o     = ctrl_q.alu_src;
    assign mem_write_o   = ctrl_q.mem_write;
    assign alu_control_o = ALU_W'(ctrl_q.alu_ctrl);
    assign beq_o         = ctrl_q.beq;
    assign bne_o         = ctrl_q.bne;
    assign blt_o         = ctrl_q.blt;
    assign bge_o         = ctrl_q.bge;
    assign bltu_o        = ctrl_q.bltu;
    assign bgeu_o        = ctrl_q.bgeu;
    assign lui_o         = ctrl_q.lui;
    assign auipc_o       = ctrl_q.auipc;
    assign u_type_o      = ctrl_q.u_type;
    assign jal_o         = ctrl_q.jal;
    assign jalr_o        = ctrl_q.jalr;
    assign ecall_o       = ctrl_q.ecall;
    assign illegal_o     = ctrl_q.illegal;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Bench for id_stage_ctrl: directed scenarios plus a random instruction stream against a stage model.
module tb_id_stage_ctrl;

    localparam int LU_STALL = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, flush = 1'b0, ecall_done = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0;

    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        mem_read, mem_to_reg, reg_write, alu_src, mem_write;
    logic [3:0]  alu_control;
    logic        beq, bne, blt, bge, bltu, bgeu, lui, auipc, u_type, jal, jalr, ecall, illegal;
    logic [17:0] obs_flags;

    logic        m_in_ready, m_out_valid;
    logic [31:0] m_out_pc, m_out_imm;
    logic [4:0]  m_out_rs1, m_out_rs2, m_out_rd;
    logic        m_mem_read, m_mem_to_reg, m_reg_write, m_alu_src, m_mem_write;
    logic [4:0]  m_alu_control;
    logic        m_beq, m_bne, m_blt, m_bge, m_bltu, m_bgeu, m_lui, m_auipc, m_u_type;
    logic        m_jal, m_jalr, m_ecall, m_illegal;

    always #5 clk = ~clk;

    id_stage_ctrl dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_instr_i(in_instr), .in_pc_i(in_pc), .flush_i(flush), .ecall_done_i(ecall_done),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pc_o(out_pc), .out_imm_o(out_imm),
        .out_rs1_o(out_rs1), .out_rs2_o(out_rs2), .out_rd_o(out_rd),
        .mem_read_o(mem_read), .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write),
        .alu_src_o(alu_src), .mem_write_o(mem_write), .alu_control_o(alu_control),
        .beq_o(beq), .bne_o(bne), .blt_o(blt), .bge_o(bge), .bltu_o(bltu), .bgeu_o(bgeu),
        .lui_o(lui), .auipc_o(auipc), .u_type_o(u_type), .jal_o(jal), .jalr_o(jalr),
        .ecall_o(ecall), .illegal_o(illegal)
    );

    id_stage_ctrl #(.RV_M(1), .ALU_W(5)) dut_m (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(m_in_ready),
        .in_instr_i(in_instr), .in_pc_i(in_pc), .flush_i(flush), .ecall_done_i(ecall_done),
        .out_valid_o(m_out_valid), .out_ready_i(out_ready), .out_pc_o(m_out_pc),
        .out_imm_o(m_out_imm), .out_rs1_o(m_out_rs1), .out_rs2_o(m_out_rs2), .out_rd_o(m_out_rd),
        .mem_read_o(m_mem_read), .mem_to_reg_o(m_mem_to_reg), .reg_write_o(m_reg_write),
        .alu_src_o(m_alu_src), .mem_write_o(m_mem_write), .alu_control_o(m_alu_control),
        .beq_o(m_beq), .bne_o(m_bne), .blt_o(m_blt), .bge_o(m_bge), .bltu_o(m_bltu),
        .bgeu_o(m_bgeu), .lui_o(m_lui), .auipc_o(m_auipc), .u_type_o(m_u_type), .jal_o(m_jal),
        .jalr_o(m_jalr), .ecall_o(m_ecall), .illegal_o(m_illegal)
    );

    assign obs_flags = {mem_read, mem_to_reg, reg_write, alu_src, mem_write, beq, bne, blt, bge,
                        bltu, bgeu, lui, auipc, u_type, jal, jalr, ecall, illegal};

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // flags order: mem_read mem_to_reg reg_write alu_src mem_write beq bne blt bge bltu bgeu
    //              lui auipc u_type jal jalr ecall illegal
    typedef struct packed {
        logic [17:0] flags;
        logic [4:0]  alu;
        logic [31:0] imm;
        logic        u1;
        logic        u2;
    } ref_t;

    function automatic ref_t decode_ref(input logic [31:0] ins, input bit rv_m);
        ref_t r;
        int   si, sgn, f3;
        bit   ld, st, br, jl, jr, oi, rr, lu, au, ec, ill, mop;
        r   = '0;
        si  = int'(ins);
        sgn = ins[31] ? -1 : 0;
        f3  = int'(ins[14:12]);
        {ld, st, br, jl, jr, oi, rr, lu, au, ec, ill, mop} = '0;
        case (ins[6:0])
            7'h03: ld = 1;
            7'h23: st = 1;
            7'h63: br = 1;
            7'h6F: jl = 1;
            7'h67: jr = 1;
            7'h13: oi = 1;
            7'h33: rr = 1;
            7'h37: lu = 1;
            7'h17: au = 1;
            7'h73: if (ins == 32'h73) ec = 1; else ill = 1;
            default: ill = 1;
        endcase
        if (rr && ins[31:25] == 7'b0000001) begin
            if (rv_m) mop = 1;
            else begin rr = 0; ill = 1; end
        end
        r.u1 = !(ins[6:0] == 7'h37 || ins[6:0] == 7'h17 || ins[6:0] == 7'h6F);
        r.u2 = (ins[6:0] == 7'h33 || ins[6:0] == 7'h23 || ins[6:0] == 7'h63);
        if (oi || (rr && !mop)) begin
            case (f3)
                0: r.alu = (rr && ins[30]) ? 5'd1 : 5'd0;
                1: r.alu = 5'd12;
                2: r.alu = 5'd8;
                3: r.alu = 5'd9;
                4: r.alu = 5'd6;
                5: r.alu = ins[30] ? 5'd14 : 5'd13;
                6: r.alu = 5'd5;
                default: r.alu = 5'd4;
            endcase
        end
        if (mop) r.alu = 5'(16 + f3);
        if (br || jl) r.alu = 5'd3;
        if (lu) r.alu = 5'd7;
        if (au) r.alu = 5'd10;
        if (ld || jr || oi || ec) r.imm = si >>> 20;
        if (st) r.imm = (si >>> 25) * 32 + int'(ins[11:7]);
        if (br) r.imm = sgn * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        if (jl) r.imm = sgn * (1 << 20) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                        + int'(ins[30:21]) * 2;
        if (lu || au) r.imm = ins & 32'hFFFF_F000;
        r.flags = {ld, ld, (ld | jl | jr | oi | rr | lu | au | ec), (ld | st | jr | oi), st,
                   br && f3 == 0, br && f3 == 1, br && f3 == 4, br && f3 == 5, br && f3 == 6,
                   br && f3 == 7, lu, au, lu | au, jl, jr, ec, ill};
        return r;
    endfunction

    // stage model state
    bit          m_valid = 0, m_wait = 0;
    int          m_lucnt = 0;
    logic [4:0]  m_lurd = '0, m_rs1 = '0, m_rs2 = '0, m_rd = '0;
    logic [17:0] m_flags = '0;
    logic [4:0]  m_alu = '0;
    logic [31:0] m_imm = '0, m_pc = '0;
    logic        last_rdy;

    task automatic drive_cycle(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                               input bit ordy, input bit fl, input bit ed);
        ref_t d;
        bit   hz, free, rdy, acc;
        #1;
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl; ecall_done = ed;
        #1;
        d    = decode_ref(ins, 1'b0);
        hz   = (m_lucnt > 0) && v && ((d.u1 && ins[19:15] == m_lurd) || (d.u2 && ins[24:20] == m_lurd));
        free = !m_valid || ordy;
        rdy  = free && !m_wait && !hz && !fl;
        last_rdy = in_ready;
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("flags", obs_flags, m_flags);
            chk("alu", alu_control, m_alu[3:0]);
            chk("imm", out_imm, m_imm);
            chk("pc", out_pc, m_pc);
            chk("idx", {out_rs1, out_rs2, out_rd}, {m_rs1, m_rs2, m_rd});
        end
        acc = v && rdy;
        if (fl) begin
            m_valid = 0; m_lucnt = 0; m_wait = 0;
        end else begin
            if (acc) begin
                m_valid = 1; m_flags = d.flags; m_alu = d.alu; m_imm = d.imm; m_pc = pc;
                m_rs1 = ins[19:15]; m_rs2 = ins[24:20]; m_rd = ins[11:7];
            end else if (free) begin
                m_valid = 0;
            end
            if (acc && d.flags[17]) begin
                if (ins[11:7] != 0) begin m_lurd = ins[11:7]; m_lucnt = LU_STALL; end
            end else if (ordy && m_lucnt > 0) begin
                m_lucnt--;
            end
            if (m_wait) begin
                if (ed) m_wait = 0;
            end else if (acc && d.flags[1]) begin
                m_wait = 1;
            end
        end
        @(posedge clk);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [4:0]  rd, rs1, rs2;
        r   = $urandom;
        rd  = 5'($urandom_range(0, 3));
        rs1 = 5'($urandom_range(0, 3));
        rs2 = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 11))
            0, 1:    return {r[31:20], rs1, 3'b010, rd, 7'h03};
            2:       return {r[31:25], rs2, rs1, 3'b010, r[11:7], 7'h23};
            3:       return {r[31:25], rs2, rs1, r[14:12], r[11:7], 7'h63};
            4:       return {r[31:12], rd, 7'h6F};
            5:       return {r[31:20], rs1, 3'b000, rd, 7'h67};
            6:       return {r[31:20], rs1, r[14:12], rd, 7'h13};
            7, 8:    return {1'b0, r[30], 4'b0, r[1] & r[0], rs2, rs1, r[14:12], rd, 7'h33};
            9:       return {r[31:12], rd, r[5] ? 7'h37 : 7'h17};
            10:      return 32'h0000_0073;
            default: return r;
        endcase
    endfunction

    logic [31:0] rnd_ins;
    bit          rnd_v, rnd_or, rnd_fl, rnd_ed;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_flags", obs_flags, 18'h0);
        chk("rst_alu", alu_control, 4'h0);
        chk("rst_data", {out_pc, out_imm, out_rs1, out_rs2, out_rd}, '0);
        chk("rst_ready", in_ready, 1'b1);
        @(posedge clk);

        // addi x5,x6,10
        drive_cycle(1, 32'h00A3_0293, 32'h0000_0100, 1, 0, 0);
        #1;
        chk("addi_valid", out_valid, 1'b1);
        chk("addi_rw_src", {reg_write, alu_src}, 2'b11);
        chk("addi_alu", alu_control, 4'b0000);
        chk("addi_imm", out_imm, 32'd10);
        chk("addi_rd_rs1", {out_rd, out_rs1}, {5'd5, 5'd6});

        // lw x5 then dependent add x7,x5,x6: one bubble
        drive_cycle(1, 32'h0000_A283, 32'h0000_0104, 1, 0, 0);
        drive_cycle(1, 32'h0062_83B3, 32'h0000_0108, 1, 0, 0);
        chk("lu_stall_rdy", last_rdy, 1'b0);
        #1 chk("lu_bubble", out_valid, 1'b0);
        drive_cycle(1, 32'h0062_83B3, 32'h0000_0108, 1, 0, 0);
        chk("lu_release_rdy", last_rdy, 1'b1);
        #1 chk("lu_add_rd", {out_valid, out_rd}, {1'b1, 5'd7});

        // ecall serialisation
        drive_cycle(1, 32'h0000_0073, 32'h0000_010C, 1, 0, 0);
        #1 chk("ecall_flags", {ecall, reg_write}, 2'b11);
        repeat (3) begin
            drive_cycle(1, 32'h00A3_0293, 32'h0000_0110, 1, 0, 0);
            chk("ecall_block", last_rdy, 1'b0);
        end
        drive_cycle(1, 32'h00A3_0293, 32'h0000_0110, 1, 0, 1);
        chk("ecall_done_cyc", last_rdy, 1'b0);
        drive_cycle(1, 32'h00A3_0293, 32'h0000_0110, 1, 0, 0);
        chk("ecall_resume", last_rdy, 1'b1);

        // mul x1,x2,x3 on both configurations
        drive_cycle(1, 32'h0231_00B3, 32'h0000_0114, 1, 0, 0);
        #1;
        chk("mul_base_ill", {illegal, reg_write}, 2'b10);
        chk("mul_m_alu", m_alu_control, 5'b10000);
        chk("mul_m_ill", {m_illegal, m_reg_write}, 2'b01);

        // all-ones word is illegal
        drive_cycle(1, 32'hFFFF_FFFF, 32'h0000_0118, 1, 0, 0);
        #1 chk("ill_flags", {out_valid, obs_flags}, {1'b1, 18'h1});

        // flush a held load; dependent add must then be accepted
        drive_cycle(1, 32'h0000_A083, 32'h0000_011C, 1, 0, 0);
        drive_cycle(1, 32'h0010_8133, 32'h0000_0120, 0, 1, 0);
        chk("flush_rdy", last_rdy, 1'b0);
        #1 chk("flush_valid", out_valid, 1'b0);
        drive_cycle(1, 32'h0010_8133, 32'h0000_0120, 1, 0, 0);
        chk("flush_lu_clear", last_rdy, 1'b1);

        // backpressure hold
        drive_cycle(1, 32'h00A3_0293, 32'h0000_0200, 1, 0, 0);
        repeat (3) begin
            drive_cycle(1, 32'h0010_0093, 32'h0000_0300, 0, 0, 0);
            chk("bp_rdy", last_rdy, 1'b0);
            #1 chk("bp_hold", {out_valid, out_pc, out_imm}, {1'b1, 32'h200, 32'd10});
        end

        for (int c = 0; c < 3000; c++) begin
            rnd_ins = gen_instr();
            rnd_v   = ($urandom_range(0, 9) < 8);
            rnd_or  = ($urandom_range(0, 3) != 0);
            rnd_fl  = ($urandom_range(0, 39) == 0);
            rnd_ed  = m_wait ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            drive_cycle(rnd_v, rnd_ins, $urandom, rnd_or, rnd_fl, rnd_ed);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
